// File: rtl/car_motion_controller_pkg.sv
// Shared definitions for the player-car path: state encoding, sprite geometry,
// road limits and frame-counter width (also consumed by the car renderer).
package car_motion_controller_pkg;

  // Sprite geometry
  localparam int unsigned CAR_WIDTH  = 16;
  localparam int unsigned CAR_HEIGHT = 32;

  // Road-local x range; the right limit keeps x + CAR_WIDTH inside 8 bits
  localparam logic [7:0] ROAD_X_MIN = 8'd0;
  localparam logic [7:0] ROAD_X_MAX = 8'(255 - CAR_WIDTH);

  // Default car placement
  localparam logic [7:0] ROAD_X_CENTER = 8'd120;
  localparam logic [9:0] ROAD_CAR_Y    = 10'(432 - CAR_HEIGHT);

  // Width of the frame counters used for the crash/respawn sequence
  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CRASH   = 2'd2,
    ST_RESPAWN = 2'd3
  } car_state_e;

endpackage

// File: rtl/car_motion_controller_frame_timer.sv
// Frame-granular down counter: loaded with a value, decremented on each
// frame_tick, holds at zero and flags done while at zero.
module car_motion_controller_frame_timer
  import car_motion_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [FRAME_CNT_W-1:0] load_val,
  input  logic                   frame_tick,
  output logic                   done
);

  logic [FRAME_CNT_W-1:0] cnt_q;
  logic [FRAME_CNT_W-1:0] cnt_d;

  // Next count: a load wins over a decrement; zero is sticky until reloaded
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (frame_tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/car_motion_controller.sv
// Player-car motion sequencer: per-frame steering with clamping, collision
// latch during the frame, crash/respawn sequencing and sprite blink gating.
module car_motion_controller
  import car_motion_controller_pkg::*;
#(
  parameter logic [7:0] X_MIN        = ROAD_X_MIN,
  parameter logic [7:0] X_MAX        = ROAD_X_MAX,
  parameter logic [7:0] X_CENTER     = ROAD_X_CENTER,
  parameter logic [9:0] CAR_Y        = ROAD_CAR_Y,
  parameter logic [7:0] STEP         = 8'd2,
  parameter logic [7:0] CRASH_FRAMES = 8'd60,
  parameter logic [7:0] SAFE_FRAMES  = 8'd90,
  parameter int         BLINK_SHIFT  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  output logic [7:0] car_position_x,
  output logic [9:0] car_position_y,
  output logic       car_visible,
  output logic       crashed,
  output logic [3:0] crash_count
);

  car_state_e state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       visible_q, visible_d;
  logic       crashed_q, crashed_d;
  logic [3:0] crash_count_q, crash_count_d;
  logic       hit_pend_q, hit_pend_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;

  logic                   timer_load;
  logic [FRAME_CNT_W-1:0] timer_load_val;
  logic                   timer_done;

  // One steering step in 9 bits so neither edge of the road can wrap
  function automatic logic [7:0] steer(input logic [7:0] x,
                                       input logic       left,
                                       input logic       right);
    logic [8:0] wide;
    logic [7:0] res;
    res = x;
    if (right && !left) begin
      wide = {1'b0, x} + {1'b0, STEP};
      res  = (wide > {1'b0, X_MAX}) ? X_MAX : wide[7:0];
    end else if (left && !right) begin
      wide = {1'b0, X_MIN} + {1'b0, STEP};
      res  = ({1'b0, x} < wide) ? X_MIN : (x - STEP);
    end
    return res;
  endfunction

  car_motion_controller_frame_timer u_frame_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_val   (timer_load_val),
    .frame_tick (frame_tick),
    .done       (timer_done)
  );

  // Next-state, position, collision latch, crash counter and blink decisions
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = CAR_Y;
    crash_count_d  = crash_count_q;
    hit_pend_d     = hit_pend_q;
    blink_cnt_d    = frame_tick ? (blink_cnt_q + 8'd1) : blink_cnt_q;
    timer_load     = 1'b0;
    timer_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        x_d        = X_CENTER;
        hit_pend_d = 1'b0;
        if (start) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (frame_tick) begin
          // A hit on the tick cycle still belongs to the frame being closed
          hit_pend_d = 1'b0;
          if (hit_pend_q || hit) begin
            state_d        = ST_CRASH;
            timer_load     = 1'b1;
            timer_load_val = CRASH_FRAMES - 8'd1;
            crash_count_d  = (crash_count_q == 4'hF) ? 4'hF : (crash_count_q + 4'd1);
            blink_cnt_d    = '0;
          end else begin
            x_d = steer(x_q, btn_left, btn_right);
          end
        end else if (hit) begin
          hit_pend_d = 1'b1;
        end
      end
      ST_CRASH: begin
        hit_pend_d = 1'b0;
        if (frame_tick && timer_done) begin
          state_d        = ST_RESPAWN;
          x_d            = X_CENTER;
          timer_load     = 1'b1;
          timer_load_val = SAFE_FRAMES - 8'd1;
        end
      end
      default: begin
        // Respawn: steerable but invulnerable
        hit_pend_d = 1'b0;
        if (frame_tick) begin
          x_d = steer(x_q, btn_left, btn_right);
          if (timer_done) begin
            state_d = ST_DRIVE;
          end
        end
      end
    endcase

    crashed_d = (state_d == ST_CRASH);
    visible_d = ((state_d == ST_CRASH) || (state_d == ST_RESPAWN))
                ? ~blink_cnt_d[BLINK_SHIFT] : 1'b1;
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      x_q           <= X_CENTER;
      y_q           <= CAR_Y;
      visible_q     <= 1'b1;
      crashed_q     <= 1'b0;
      crash_count_q <= 4'd0;
      hit_pend_q    <= 1'b0;
      blink_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      visible_q     <= visible_d;
      crashed_q     <= crashed_d;
      crash_count_q <= crash_count_d;
      hit_pend_q    <= hit_pend_d;
      blink_cnt_q   <= blink_cnt_d;
    end
  end

  assign car_position_x = x_q;
  assign car_position_y = y_q;
  assign car_visible    = visible_q;
  assign crashed        = crashed_q;
  assign crash_count    = crash_count_q;

endmodule
